// File: rtl/weight_sched_pkg.sv
// rtl/weight_sched_pkg.sv - shared state encoding and default sizes for the weight fetch sequencer
package weight_sched_pkg;

  localparam int DEF_DAT_WIDTH  = 96;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_CNT_WIDTH  = 16;

  localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
  localparam logic [2:0] ST_INIT_ENC  = 3'd1;
  localparam logic [2:0] ST_FETCH_ENC = 3'd2;
  localparam logic [2:0] ST_DRAIN_ENC = 3'd3;
  localparam logic [2:0] ST_DONE_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_INIT  = ST_INIT_ENC,
    ST_FETCH = ST_FETCH_ENC,
    ST_DRAIN = ST_DRAIN_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/weight_sched_if.sv
// rtl/weight_sched_if.sv - request-unit and PE weight-port signals of the sequencer
interface weight_sched_if import weight_sched_pkg::*; #(
  parameter int DAT_WIDTH = DEF_DAT_WIDTH
);

  logic                 wrq_rst;
  logic                 wrq_req;
  logic [DAT_WIDTH-1:0] wrq_dat;
  logic                 wrq_vld;
  logic [DAT_WIDTH-1:0] w_dat;
  logic                 w_vld;
  logic                 w_rdy;
  logic                 w_last;

  modport master (
    output wrq_rst, wrq_req, w_dat, w_vld, w_last,
    input  wrq_dat, wrq_vld, w_rdy
  );

  modport slave (
    input  wrq_rst, wrq_req, w_dat, w_vld, w_last,
    output wrq_dat, wrq_vld, w_rdy
  );

endinterface

// File: rtl/weight_fifo.sv
// rtl/weight_fifo.sv - synchronous show-ahead FIFO; head word is visible whenever not empty
module weight_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is forced to zero when empty so the port never shows stale words.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/weight_sched.sv
// rtl/weight_sched.sv - layer sequencer: resets the request unit, issues credit-limited requests, buffers words to the PE port
module weight_sched
  import weight_sched_pkg::*;
#(
  parameter int DAT_WIDTH  = DEF_DAT_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] cfg_num_taps,
  input  logic [CNT_WIDTH-1:0] cfg_num_kgrp,
  output logic                 busy,
  output logic                 done,
  output logic                 err_ovf,
  weight_sched_if.master       wif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = 2 * CNT_WIDTH;
  localparam logic [PW+1:0] DEPTH_W = (PW+2)'(FIFO_DEPTH);

  state_t               state;
  logic [CNT_WIDTH-1:0] taps_q;
  logic [CNT_WIDTH-1:0] kgrp_q;
  logic [CNT_WIDTH-1:0] tap_cnt;
  logic [CNT_WIDTH-1:0] grp_cnt;
  logic [TW-1:0]        total;
  logic [TW-1:0]        req_cnt;
  logic [PW:0]          outstanding;
  logic [PW:0]          fifo_count;
  logic [PW+1:0]        inflight;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DAT_WIDTH:0]   fifo_dout;
  logic                 start_ok;
  logic                 cfg_zero;
  logic                 push;
  logic                 pop;
  logic                 req;
  logic                 tap_wrap;
  logic                 wrq_rst_q;

  // busy stays high through the done cycle, so a start there is still ignored.
  assign start_ok = start & ~busy & (state == ST_IDLE);
  assign cfg_zero = (cfg_num_taps == '0) | (cfg_num_kgrp == '0);

  // Credit: never request more than the FIFO can absorb, counting words in flight.
  assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};
  assign req      = (state == ST_FETCH) & (req_cnt < total) & (inflight < DEPTH_W);

  assign push     = wif.wrq_vld & (state != ST_IDLE);
  assign pop      = wif.w_vld & wif.w_rdy;
  assign tap_wrap = (tap_cnt == taps_q - 1'b1);

  assign wif.wrq_req = req;
  assign wif.wrq_rst = wrq_rst_q;
  assign wif.w_vld   = ~fifo_empty;
  assign wif.w_dat   = fifo_dout[DAT_WIDTH-1:0];
  assign wif.w_last  = fifo_dout[DAT_WIDTH];

  weight_fifo #(
    .WIDTH (DAT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({tap_wrap, wif.wrq_dat}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrq_rst_q <= 1'b0;
      taps_q    <= '0;
      kgrp_q    <= '0;
      total     <= '0;
      req_cnt   <= '0;
      err_ovf   <= 1'b0;
    end else begin
      done      <= 1'b0;
      wrq_rst_q <= 1'b0;
      if (done) begin
        busy <= 1'b0;
      end
      if (req) begin
        req_cnt <= req_cnt + 1'b1;
      end
      if (push & fifo_full) begin
        err_ovf <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            taps_q  <= cfg_num_taps;
            kgrp_q  <= cfg_num_kgrp;
            total   <= TW'(cfg_num_taps) * TW'(cfg_num_kgrp);
            req_cnt <= '0;
            err_ovf <= 1'b0;
            busy    <= 1'b1;
            if (cfg_zero) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_INIT;
              wrq_rst_q <= 1'b1;
            end
          end
        end
        ST_INIT:  state <= ST_FETCH;
        ST_FETCH: begin
          if (req && (req_cnt == total - 1'b1)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if ((outstanding == '0) && fifo_empty && !pop) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tap/group position of the next word to arrive, plus words requested but not yet returned.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      tap_cnt     <= '0;
      grp_cnt     <= '0;
      outstanding <= '0;
    end else begin
      if (push & ~fifo_full) begin
        if (tap_wrap) begin
          tap_cnt <= '0;
          grp_cnt <= (grp_cnt == kgrp_q - 1'b1) ? '0 : grp_cnt + 1'b1;
        end else begin
          tap_cnt <= tap_cnt + 1'b1;
        end
      end
      case ({req, push})
        2'b10: outstanding <= outstanding + 1'b1;
        2'b01: begin
          if (outstanding != '0) begin
            outstanding <= outstanding - 1'b1;
          end
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_sched.sv
// tb/tb_weight_sched.sv - directed bench for weight_sched with a fixed-latency request-unit model
module tb_weight_sched;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_num_taps;
  logic [15:0] cfg_num_kgrp;
  logic        busy;
  logic        done;
  logic        err_ovf;

  logic        resp_vld = 1'b0;
  logic [95:0] resp_dat = '0;
  logic        inj_vld;
  logic        rdy;
  int          lat;

  int          n_pass = 0;
  int          n_total = 0;

  int          cyc = 0;
  int          due_q[$];
  int          resp_idx = 0;

  logic        req_s = 1'b0;
  logic        wrst_s = 1'b0;
  logic        rst_s = 1'b0;
  int          n_req = 0;
  int          n_wrst = 0;
  int          n_done = 0;
  int          beat_cnt = 0;
  logic [95:0] beat_dat [256];
  logic        beat_last [256];

  weight_sched_if #(.DAT_WIDTH(96)) wif ();

  assign wif.wrq_vld = resp_vld | inj_vld;
  assign wif.wrq_dat = inj_vld ? {96{1'b1}} : resp_dat;
  assign wif.w_rdy   = rdy;

  weight_sched dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_num_taps (cfg_num_taps),
    .cfg_num_kgrp (cfg_num_kgrp),
    .busy         (busy),
    .done         (done),
    .err_ovf      (err_ovf),
    .wif          (wif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] mkdat(input int k);
    logic [31:0] u;
    u = k;
    return {32'hA5A5_0000 + u, ~u, 32'h00C3_0000 + u};
  endfunction

  // Request unit: every request returns its word lat cycles later, realigned by wrq_rst.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst_s || wrst_s) begin
      due_q.delete();
      resp_idx = 0;
    end else if (req_s) begin
      due_q.push_back(cyc - 1 + lat);
    end
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      void'(due_q.pop_front());
      resp_vld = 1'b1;
      resp_dat = mkdat(resp_idx);
      resp_idx = resp_idx + 1;
    end else begin
      resp_vld = 1'b0;
    end
  end

  always @(negedge clk) begin
    req_s  = wif.wrq_req;
    wrst_s = wif.wrq_rst;
    rst_s  = rst;
    if (wif.wrq_req) n_req = n_req + 1;
    if (wif.wrq_rst) n_wrst = n_wrst + 1;
    if (done) n_done = n_done + 1;
    if (wif.w_vld && wif.w_rdy) begin
      beat_dat[beat_cnt % 256]  = wif.w_dat;
      beat_last[beat_cnt % 256] = wif.w_last;
      beat_cnt = beat_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total = n_total + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic do_start(input logic [15:0] taps, input logic [15:0] kgrp, output int t0);
    @(posedge clk); #1;
    cfg_num_taps = taps;
    cfg_num_kgrp = kgrp;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    int k;
    k = 0;
    dc = -1;
    while (k < 400) begin
      @(negedge clk);
      k++;
      if (done) begin
        dc = cyc;
        break;
      end
    end
    chk("done_seen", dc >= 0, 1'b1);
    if (dc >= 0) begin
      chk("busy_at_done", busy, 1'b1);
      @(negedge clk);
      chk("busy_after_done", busy, 1'b0);
    end
  endtask

  task automatic check_beats(input string tag, input int s, input int n, input int taps);
    for (int j = 0; j < n; j++) begin
      chk({tag, "_dat"}, beat_dat[(s + j) % 256], mkdat(j));
      chk({tag, "_last"}, beat_last[(s + j) % 256], (j % taps) == taps - 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dc, r0, w0, d0, b0;
    rst = 1'b1; start = 1'b0; cfg_num_taps = '0; cfg_num_kgrp = '0;
    inj_vld = 1'b0; rdy = 1'b1; lat = 2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_wrq_rst", wif.wrq_rst, 1'b0);
    chk("rst_wrq_req", wif.wrq_req, 1'b0);
    chk("rst_w_vld", wif.w_vld, 1'b0);
    chk("rst_w_last", wif.w_last, 1'b0);
    chk("rst_w_dat", wif.w_dat, 96'd0);
    chk("rst_err_ovf", err_ovf, 1'b0);

    // Returned word while idle must not reach the FIFO
    b0 = beat_cnt;
    @(posedge clk); #1 inj_vld = 1'b1;
    @(posedge clk); #1 inj_vld = 1'b0;
    @(negedge clk);
    chk("idle_vld_ignored", wif.w_vld, 1'b0);
    chk("idle_no_beat", beat_cnt - b0, 0);

    // taps=9 kgrp=2, PE always ready
    r0 = n_req; w0 = n_wrst; d0 = n_done; b0 = beat_cnt;
    do_start(9, 2, t0);
    @(negedge clk);
    chk("t1_wrq_rst_c1", wif.wrq_rst, 1'b1);
    chk("t1_busy_c1", busy, 1'b1);
    chk("t1_req_c1", wif.wrq_req, 1'b0);
    @(negedge clk);
    chk("t1_req_c2", wif.wrq_req, 1'b1);
    chk("t1_wrq_rst_c2", wif.wrq_rst, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t1_w_vld_c4", wif.w_vld, 1'b0);
    @(negedge clk);
    chk("t1_w_vld_c5", wif.w_vld, 1'b1);
    wait_done(dc);
    repeat (3) @(negedge clk);
    chk("t1_req_count", n_req - r0, 18);
    chk("t1_wrq_rst_count", n_wrst - w0, 1);
    chk("t1_done_count", n_done - d0, 1);
    chk("t1_beat_count", beat_cnt - b0, 18);
    chk("t1_err_ovf", err_ovf, 1'b0);
    check_beats("t1", b0, 18, 9);

    // Same layer with PE stalled for 20 cycles: credit limit holds requests at 4
    rdy = 1'b0;
    r0 = n_req; d0 = n_done; b0 = beat_cnt;
    do_start(9, 2, t0);
    repeat (20) @(negedge clk);
    chk("t2_req_stalled", n_req - r0, 4);
    chk("t2_w_vld_stalled", wif.w_vld, 1'b1);
    chk("t2_no_beat_stalled", beat_cnt - b0, 0);
    chk("t2_err_ovf_stalled", err_ovf, 1'b0);
    @(posedge clk); #1 rdy = 1'b1;
    wait_done(dc);
    repeat (3) @(negedge clk);
    chk("t2_req_count", n_req - r0, 18);
    chk("t2_beat_count", beat_cnt - b0, 18);
    chk("t2_done_count", n_done - d0, 1);
    chk("t2_err_ovf", err_ovf, 1'b0);
    check_beats("t2", b0, 18, 9);

    // Zero-sized layers finish without touching the request unit
    r0 = n_req; w0 = n_wrst; d0 = n_done;
    do_start(0, 5, t0);
    wait_done(dc);
    chk("t3a_done_latency", dc - t0, 2);
    repeat (3) @(negedge clk);
    chk("t3a_req_count", n_req - r0, 0);
    chk("t3a_wrq_rst_count", n_wrst - w0, 0);
    chk("t3a_done_count", n_done - d0, 1);
    r0 = n_req; w0 = n_wrst; d0 = n_done;
    do_start(3, 0, t0);
    wait_done(dc);
    chk("t3b_done_latency", dc - t0, 2);
    repeat (3) @(negedge clk);
    chk("t3b_req_count", n_req - r0, 0);
    chk("t3b_wrq_rst_count", n_wrst - w0, 0);
    chk("t3b_done_count", n_done - d0, 1);

    // Second start while busy is ignored
    r0 = n_req; w0 = n_wrst; d0 = n_done; b0 = beat_cnt;
    do_start(3, 2, t0);
    repeat (3) @(posedge clk);
    #1;
    cfg_num_taps = 16'd7; cfg_num_kgrp = 16'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(dc);
    repeat (3) @(negedge clk);
    chk("t4_req_count", n_req - r0, 6);
    chk("t4_wrq_rst_count", n_wrst - w0, 1);
    chk("t4_done_count", n_done - d0, 1);
    chk("t4_beat_count", beat_cnt - b0, 6);
    check_beats("t4", b0, 6, 3);

    // Reset in the middle of FETCH aborts, then a fresh layer runs cleanly
    d0 = n_done;
    do_start(9, 2, t0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_busy_after_rst", busy, 1'b0);
    chk("t5_w_vld_after_rst", wif.w_vld, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5_no_done", n_done - d0, 0);
    r0 = n_req; d0 = n_done; b0 = beat_cnt;
    do_start(2, 3, t0);
    wait_done(dc);
    repeat (3) @(negedge clk);
    chk("t5_req_count", n_req - r0, 6);
    chk("t5_beat_count", beat_cnt - b0, 6);
    chk("t5_done_count", n_done - d0, 1);
    check_beats("t5", b0, 6, 2);

    // Injected return while the FIFO is full: dropped, sticky error until next start
    rdy = 1'b0;
    r0 = n_req; b0 = beat_cnt;
    do_start(4, 2, t0);
    repeat (11) @(negedge clk);
    chk("t6_req_stalled", n_req - r0, 4);
    chk("t6_err_before", err_ovf, 1'b0);
    chk("t6_full_w_vld", wif.w_vld, 1'b1);
    @(posedge clk); #1 inj_vld = 1'b1;
    @(posedge clk); #1 inj_vld = 1'b0;
    @(negedge clk);
    chk("t6_err_set", err_ovf, 1'b1);
    @(posedge clk); #1 rdy = 1'b1;
    wait_done(dc);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", err_ovf, 1'b1);
    chk("t6_req_count", n_req - r0, 8);
    chk("t6_beat_count", beat_cnt - b0, 8);
    check_beats("t6", b0, 8, 4);
    b0 = beat_cnt;
    do_start(1, 1, t0);
    @(negedge clk);
    chk("t6_err_cleared", err_ovf, 1'b0);
    wait_done(dc);
    repeat (3) @(negedge clk);
    chk("t6b_beat_count", beat_cnt - b0, 1);
    check_beats("t6b", b0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
